// File: rtl/dpad_event_queue_if.sv
// Event handshake between the d-pad conditioner and the core that drains it.
//   evt_valid  : head entry present (driven by the queue)
//   evt_ready  : consumer takes the head entry this cycle (driven by the core)
//   evt_code   : {press(1)/release(0), dir[1:0]}, dir 0=up 1=down 2=left 3=right
// master = event source (dpad_event_queue), slave = event consumer.
interface dpad_event_queue_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [2:0] evt_code;

   modport master (output evt_valid, output evt_code, input evt_ready);
   modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/dpad_event_queue.sv
// dpad_event_queue
// Conditions the four raw active-low d-pad pins: 2-FF synchronise, debounce,
// detect press/release, and queue the resulting 3-bit events in a show-ahead
// FIFO drained over a valid/ready handshake.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   up_/down_/left_/right_ raw active-low buttons (asynchronous)
//   evt (master)           evt_valid / evt_ready / evt_code handshake
//   level[3:0]             debounced pressed levels, bit index = dir
//   evt_count              FIFO occupancy
//   overflow               sticky "event dropped" flag
//   clr_overflow           clears overflow (a same-cycle drop wins)
// Optional feature: define DPAD_REPEAT_EN to enable per-button auto-repeat
// (REPEAT_DELAY then every REPEAT_PERIOD cycles while held). With the macro
// undefined only edges generate events and REPEAT_* are unused.
module dpad_event_queue #(
   parameter int DEBOUNCE_CYCLES = 16000,
   parameter int FIFO_DEPTH      = 4,
   parameter int FIFO_AW         = 2,
   parameter int REPEAT_DELAY    = 320000,
   parameter int REPEAT_PERIOD   = 64000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               up_,
   input  logic               down_,
   input  logic               left_,
   input  logic               right_,
   dpad_event_queue_if.master evt,
   output logic [3:0]         level,
   output logic [FIFO_AW:0]   evt_count,
   output logic               overflow,
   input  logic               clr_overflow
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

   logic [3:0]    pin;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    raw;
   logic [CW-1:0] cnt [4];
   logic [3:0]    tog;
   logic [3:0]    pend;
   logic [3:0]    grant;
   logic [3:0]    rep_hit;
   logic          push;
   logic [2:0]    push_code;

   logic [2:0]         mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               full;
   logic               pop;
   logic               wr_en;
   logic               drop;

   assign pin = {right_, left_, down_, up_};

   // Synchroniser loads 1 on reset so every button starts out released.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   assign raw = ~sync2;

   always_comb begin
      tog = '0;
      for (int i = 0; i < 4; i++)
         tog[i] = (raw[i] != level[i]) && (cnt[i] == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         level <= level ^ tog;
         for (int i = 0; i < 4; i++) begin
            if ((raw[i] == level[i]) || tog[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

`ifdef DPAD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   logic [RW-1:0] rcnt [4];
   logic [3:0]    rfirst;

   // rfirst selects the initial delay; afterwards the period applies.
   always_comb begin
      rep_hit = '0;
      for (int i = 0; i < 4; i++)
         rep_hit[i] = level[i] && !tog[i] &&
                      (rcnt[i] == (rfirst[i] ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rfirst <= '1;
         for (int i = 0; i < 4; i++) rcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!level[i] || tog[i]) begin
               rcnt[i]   <= '0;
               rfirst[i] <= 1'b1;
            end else if (rep_hit[i]) begin
               rcnt[i]   <= '0;
               rfirst[i] <= 1'b0;
            end else begin
               rcnt[i] <= rcnt[i] + RW'(1);
            end
         end
      end
   end
`else
   logic unused_repeat;
   assign rep_hit       = '0;
   assign unused_repeat = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
`endif

   // Lowest-index pending button wins; the rest wait a cycle or more.
   always_comb begin
      grant     = '0;
      push_code = '0;
      push      = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (pend[i] && !push) begin
            push      = 1'b1;
            grant[i]  = 1'b1;
            push_code = {level[i], 2'(i)};
         end
      end
   end

   assign evt.evt_valid = (evt_count != '0);
   assign evt.evt_code  = evt.evt_valid ? mem[rd_ptr] : 3'b000;
   assign full          = (evt_count == FULL_CNT);
   assign pop           = evt.evt_valid & evt.evt_ready;
   assign wr_en         = push & (~full | pop);
   assign drop          = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_code;
   end

   // A granted pend clears even if its event is dropped on a full FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         pend <= (pend & ~grant) | tog | rep_hit;
         if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({wr_en, pop})
            2'b10:   evt_count <= evt_count + (FIFO_AW+1)'(1);
            2'b01:   evt_count <= evt_count - (FIFO_AW+1)'(1);
            default: evt_count <= evt_count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule
